// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback (P) and the multicycle mul/div unit (M). P normally wins, but M
//   takes the port after being refused STARVE_LIMIT consecutive cycles. A
//   32-entry scoreboard marks registers whose M result is still outstanding so
//   decode can stall on RAW hazards and avoid double-issuing to one register.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   p_valid/p_ready/p_dest/p_data   pipeline writeback handshake
//   m_valid/m_ready/m_dest/m_data   M-unit result handshake
//   iss_valid/iss_dest/iss_ready    M-instruction issue from decode
//   src_a/src_b -> busy_a/busy_b    decode source hazard flags
//   rf_load/rf_dest/rf_in           register file write port
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [4:0]      p_dest,
  input  logic [XLEN-1:0] p_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_dest,
  input  logic [XLEN-1:0] m_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_dest,
  output logic            iss_ready,
  input  logic [4:0]      src_a,
  input  logic [4:0]      src_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            rf_load,
  output logic [4:0]      rf_dest,
  output logic [XLEN-1:0] rf_in
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic          starve;
  logic          m_grant;
  logic          p_grant;
  logic          iss_set;

  assign starve = (wait_cnt_q == CW'(STARVE_LIMIT));

  // Grants are forced low while in reset so nothing is handshaken then.
  assign m_grant = !rst && m_valid && (!p_valid || starve);
  assign p_grant = !rst && p_valid && !m_grant;

  assign m_ready = m_grant;
  assign p_ready = p_grant;

  // A same-cycle M commit to the register frees it, so issue/read need not
  // wait for the scoreboard update at the edge (write-through read path).
  assign iss_ready = !rst && ((iss_dest == 5'd0) || !pending_q[iss_dest] ||
                              (m_grant && (m_dest == iss_dest)));
  assign busy_a    = !rst && pending_q[src_a] && !(m_grant && (m_dest == src_a));
  assign busy_b    = !rst && pending_q[src_b] && !(m_grant && (m_dest == src_b));

  assign iss_set   = iss_valid && iss_ready && (iss_dest != 5'd0);

  always_comb begin
    rf_load = 1'b0;
    rf_dest = 5'd0;
    rf_in   = '0;
    if (m_grant) begin
      rf_load = (m_dest != 5'd0);
      rf_dest = m_dest;
      rf_in   = m_data;
    end else if (p_grant) begin
      rf_load = (p_dest != 5'd0);
      rf_dest = p_dest;
      rf_in   = p_data;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m_valid || m_grant) begin
      wait_cnt_d = '0;
    end else if (!starve) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  // Clear first, then set, so a re-issue in the commit cycle keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (m_grant) begin
      pending_d[m_dest] = 1'b0;
    end
    if (iss_set) begin
      pending_d[iss_dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      pending_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int SL   = 4;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_valid, p_ready;
  logic [4:0]      p_dest;
  logic [XLEN-1:0] p_data;
  logic            m_valid, m_ready;
  logic [4:0]      m_dest;
  logic [XLEN-1:0] m_data;
  logic            iss_valid, iss_ready;
  logic [4:0]      iss_dest;
  logic [4:0]      src_a, src_b;
  logic            busy_a, busy_b;
  logic            rf_load;
  logic [4:0]      rf_dest;
  logic [XLEN-1:0] rf_in;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(SL), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_dest(p_dest), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_dest(m_dest), .m_data(m_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .src_a(src_a), .src_b(src_b), .busy_a(busy_a), .busy_b(busy_b),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of registers with an outstanding M result, and the
  // number of consecutive cycles the current M result has been refused.
  bit ref_pend[32];
  int ref_refused;

  // Observations from the most recent step, for directed checks.
  logic obs_m, obs_p, obs_load, obs_busy_a, obs_iss_ready;
  bit   exp_mg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    p_valid = 0; p_dest = 0; p_data = 0;
    m_valid = 0; m_dest = 0; m_data = 0;
    iss_valid = 0; iss_dest = 0; src_a = 0; src_b = 0;
  endtask

  // Evaluate one cycle: inputs are already driven; check at the falling edge,
  // advance the model, then move to just after the next rising edge.
  task automatic step();
    bit mg, pg, ir, ba, bb, fire;
    logic [4:0]      d;
    logic [XLEN-1:0] dat;
    @(negedge clk);
    if (rst) begin
      mg = 0; pg = 0; ir = 0; ba = 0; bb = 0;
    end else begin
      if (m_valid && m_dest != 0)
        assert (ref_pend[m_dest]) else $error("stimulus: M result to non-pending x%0d", m_dest);
      mg = m_valid && (!p_valid || ref_refused >= SL);
      pg = p_valid && !mg;
      ir = (iss_dest == 0) || !ref_pend[iss_dest] || (mg && m_dest == iss_dest);
      ba = (src_a != 0) && ref_pend[src_a] && !(mg && m_dest == src_a);
      bb = (src_b != 0) && ref_pend[src_b] && !(mg && m_dest == src_b);
    end
    fire = mg || pg;
    d    = mg ? m_dest : (pg ? p_dest : 5'd0);
    dat  = mg ? m_data : (pg ? p_data : '0);
    chk("m_ready",   m_ready,   mg);
    chk("p_ready",   p_ready,   pg);
    chk("iss_ready", iss_ready, ir);
    chk("busy_a",    busy_a,    ba);
    chk("busy_b",    busy_b,    bb);
    chk("rf_load",   rf_load,   fire && d != 0);
    chk("rf_dest",   rf_dest,   d);
    chk("rf_in",     rf_in,     dat);
    obs_m = m_ready; obs_p = p_ready; obs_load = rf_load;
    obs_busy_a = busy_a; obs_iss_ready = iss_ready;
    exp_mg = mg;
    if (rst) begin
      foreach (ref_pend[i]) ref_pend[i] = 0;
      ref_refused = 0;
    end else begin
      if (mg) ref_pend[m_dest] = 0;
      if (iss_valid && ir && iss_dest != 0) ref_pend[iss_dest] = 1;
      if (!m_valid || mg) ref_refused = 0;
      else if (ref_refused < SL) ref_refused++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic contention(input string tag);
    idle();
    p_valid = 1; p_dest = 5'd1; m_valid = 1; m_dest = 5'd0;
    for (int i = 0; i < 10; i++) begin
      p_data = $urandom; m_data = $urandom;
      step();
      chk({tag, "_m"}, obs_m, (i == 4 || i == 9));
      chk({tag, "_p"}, obs_p, !(i == 4 || i == 9));
    end
    idle();
  endtask

  initial begin
    foreach (ref_pend[i]) ref_pend[i] = 0;
    ref_refused = 0;
    idle();
    rst = 1;
    @(posedge clk); #1;
    // Reset gating: everything quiet even with requests present.
    p_valid = 1; p_dest = 5'd3; m_valid = 1; iss_valid = 1; iss_dest = 5'd4;
    step();
    step();
    idle();
    rst = 0;

    // P only.
    p_valid = 1; p_dest = 5'd5; p_data = 32'hDEADBEEF;
    step();
    chk("p_only_ready", obs_p, 1'b1);
    chk("p_only_load",  obs_load, 1'b1);
    p_dest = 5'd0;
    step();
    chk("p_x0_ready", obs_p, 1'b1);
    chk("p_x0_load",  obs_load, 1'b0);
    idle();
    step();

    contention("cont");

    // Scoreboard: issue, hazard, commit.
    iss_valid = 1; iss_dest = 5'd7;
    step();
    src_a = 5'd7;
    step();
    chk("sb_busy", obs_busy_a, 1'b1);
    chk("sb_reissue", obs_iss_ready, 1'b0);
    iss_valid = 0;
    m_valid = 1; m_dest = 5'd7; m_data = 32'h1234_5678;
    step();
    chk("sb_commit_busy", obs_busy_a, 1'b0);
    chk("sb_commit_iss", obs_iss_ready, 1'b1);
    idle(); src_a = 5'd7;
    step();
    chk("sb_cleared", obs_busy_a, 1'b0);

    // Same-cycle set and clear on x9.
    idle(); iss_valid = 1; iss_dest = 5'd9;
    step();
    m_valid = 1; m_dest = 5'd9; m_data = 32'hCAFE;
    step();
    idle(); src_a = 5'd9;
    step();
    chk("setclr_busy", obs_busy_a, 1'b1);
    m_valid = 1; m_dest = 5'd9;
    step();
    idle();

    // x0 handling.
    iss_valid = 1; iss_dest = 5'd0;
    step();
    idle(); src_a = 5'd0;
    step();
    chk("x0_busy", obs_busy_a, 1'b0);
    m_valid = 1; m_dest = 5'd0; m_data = 32'h55;
    step();
    chk("x0_m_ready", obs_m, 1'b1);
    chk("x0_m_load",  obs_load, 1'b0);
    idle();

    // Reset mid-operation with pending {3,12} and two refusals accumulated.
    iss_valid = 1; iss_dest = 5'd3;  step();
    iss_valid = 1; iss_dest = 5'd12; step();
    idle();
    p_valid = 1; p_dest = 5'd2; m_valid = 1; m_dest = 5'd3;
    step(); step();
    idle(); rst = 1;
    step();
    rst = 0; src_a = 5'd3; src_b = 5'd12;
    step();
    chk("rst_busy_a", obs_busy_a, 1'b0);
    contention("rst_cont");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int cand[$];
      if (!m_valid || exp_mg) begin
        m_valid = 0;
        cand.delete();
        for (int r = 1; r < 32; r++) if (ref_pend[r]) cand.push_back(r);
        if (cand.size() > 0 && ($urandom_range(0, 1) == 1)) begin
          m_valid = 1;
          m_dest  = 5'(cand[$urandom_range(0, cand.size() - 1)]);
          m_data  = $urandom;
        end
      end
      rst       = ($urandom_range(0, 199) == 0);
      p_valid   = ($urandom_range(0, 3) != 0);
      p_dest    = 5'($urandom);
      p_data    = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_dest  = 5'($urandom);
      src_a     = 5'($urandom);
      src_b     = 5'($urandom);
      step();
      if (rst) m_valid = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
